// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the fetch PC sequencer
// Exports: ADDR_W, PC_STEP, DEFAULT_RESET_PC, DEFAULT_EXC_VECTOR, pc_state_t
package pc_pkg;

  localparam int unsigned ADDR_W = 32;

  // One fetch word per accepted fetch.
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC   = 32'h0040_0000;
  localparam logic [ADDR_W-1:0] DEFAULT_EXC_VECTOR = 32'h0040_0800;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-fetch PC sequencer with invalid-PC fault capture
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   stall         hold the current VPC
//   redirect      load word-aligned redirect_pc as the next VPC
//   redirect_pc   branch/jump target
//   fault_ack     acknowledge a pending fault, restart at EXC_VECTOR
//   IPC           invalid-PC flag from the decoder (combinational from VPC)
//   VPC           registered fetch PC to the decoder
//   valid         VPC is a live fetch this cycle
//   fault         invalid-PC fault pending
//   epc           VPC captured at the last fault
//   fetch_count   saturating count of accepted fetches
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              fault_ack,
  input  logic              IPC,
  output logic [ADDR_W-1:0] VPC,
  output logic              valid,
  output logic              fault,
  output logic [ADDR_W-1:0] epc,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  pc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] vpc_q, vpc_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              accept;

  // Redirect targets are forced word-aligned, so the low bits are dropped.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vpc_q   <= RESET_PC;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      epc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      vpc_q   <= vpc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      epc_q   <= epc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vpc_d   = vpc_q;
    valid_d = valid_q;
    fault_d = fault_q;
    epc_d   = epc_q;

    unique case (state_q)
      IDLE: begin
        // Single bubble after reset; the reset PC is presented unchanged.
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN: begin
        if (IPC) begin
          // The bad PC is held so the decoder keeps seeing it while faulted.
          epc_d   = vpc_q;
          fault_d = 1'b1;
          valid_d = 1'b0;
          state_d = FAULT;
        end else if (redirect) begin
          vpc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (!stall) begin
          vpc_d = vpc_q + PC_STEP;
        end
      end
      FAULT: begin
        if (fault_ack) begin
          vpc_d   = EXC_VECTOR;
          fault_d = 1'b0;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // valid is only high in RUN, so this also excludes IDLE and FAULT cycles.
  assign accept = valid_q & ~IPC & ~stall;

  always_comb begin
    count_d = count_q;
    if (accept && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  assign VPC         = vpc_q;
  assign valid       = valid_q;
  assign fault       = fault_q;
  assign epc         = epc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault_ack;

  logic        ipc;
  logic [31:0] vpc;
  logic        valid;
  logic        fault;
  logic [31:0] epc;
  logic [15:0] fetch_count;

  logic        ipc4;
  logic [31:0] vpc4;
  logic        valid4;
  logic        fault4;
  logic [31:0] epc4;
  logic [3:0]  fetch_count4;

  int errors = 0;
  int checks = 0;

  // Decoder stand-in: legal PCs are the 4 KB text page at 0x0040_0000
  // plus a small page either side of the 32-bit wrap point.
  function automatic logic pc_invalid(input logic [31:0] pc);
    logic ok;
    ok = (pc >= 32'h0040_0000 && pc < 32'h0040_1000) ||
         (pc >= 32'hFFFF_FFF0) || (pc < 32'h0000_0010);
    return !ok;
  endfunction

  assign ipc  = pc_invalid(vpc);
  assign ipc4 = pc_invalid(vpc4);

  pc_sequencer u_dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fault_ack   (fault_ack),
    .IPC         (ipc),
    .VPC         (vpc),
    .valid       (valid),
    .fault       (fault),
    .epc         (epc),
    .fetch_count (fetch_count)
  );

  pc_sequencer #(.CNT_W(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fault_ack   (fault_ack),
    .IPC         (ipc4),
    .VPC         (vpc4),
    .valid       (valid4),
    .fault       (fault4),
    .epc         (epc4),
    .fetch_count (fetch_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_vpc, input logic e_valid,
                             input logic e_fault, input logic [31:0] e_epc, input logic [15:0] e_cnt);
    check({tag, ".vpc"},   vpc,                e_vpc);
    check({tag, ".valid"}, {31'd0, valid},     {31'd0, e_valid});
    check({tag, ".fault"}, {31'd0, fault},     {31'd0, e_fault});
    check({tag, ".epc"},   epc,                e_epc);
    check({tag, ".count"}, {16'd0, fetch_count}, {16'd0, e_cnt});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; fault_ack = 1'b0;
    tick();
    tick();
    check_state("reset", 32'h0040_0000, 1'b0, 1'b0, 32'h0, 16'd0);
    check("reset.count4", {28'd0, fetch_count4}, 32'd0);

    rst = 1'b0;
    tick();
    check_state("bubble_done", 32'h0040_0000, 1'b1, 1'b0, 32'h0, 16'd0);
    tick();
    check_state("fetch1", 32'h0040_0004, 1'b1, 1'b0, 32'h0, 16'd1);
    tick();
    check_state("fetch2", 32'h0040_0008, 1'b1, 1'b0, 32'h0, 16'd2);

    stall = 1'b1;
    tick();
    check_state("stall1", 32'h0040_0008, 1'b1, 1'b0, 32'h0, 16'd2);
    tick();
    tick();
    check_state("stall3", 32'h0040_0008, 1'b1, 1'b0, 32'h0, 16'd2);
    stall = 1'b0;
    tick();
    check_state("unstall", 32'h0040_000C, 1'b1, 1'b0, 32'h0, 16'd3);

    fault_ack = 1'b1;
    tick();
    check_state("ack_ignored", 32'h0040_0010, 1'b1, 1'b0, 32'h0, 16'd4);
    fault_ack = 1'b0;

    redirect = 1'b1; redirect_pc = 32'h0040_0103; stall = 1'b1;
    tick();
    check_state("redir_over_stall", 32'h0040_0100, 1'b1, 1'b0, 32'h0, 16'd4);
    stall = 1'b0;

    redirect_pc = 32'hFFFF_FFFE;
    tick();
    check_state("redir_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 16'd5);
    redirect = 1'b0;
    tick();
    check_state("wrap", 32'h0000_0000, 1'b1, 1'b0, 32'h0, 16'd6);
    tick();
    check_state("post_wrap", 32'h0000_0004, 1'b1, 1'b0, 32'h0, 16'd7);

    redirect = 1'b1; redirect_pc = 32'h0040_2000;
    tick();
    check_state("redir_bad", 32'h0040_2000, 1'b1, 1'b0, 32'h0, 16'd8);
    redirect = 1'b0;
    tick();
    check_state("fault_raise", 32'h0040_2000, 1'b0, 1'b1, 32'h0040_2000, 16'd8);

    redirect = 1'b1; redirect_pc = 32'h0040_0200; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    tick();
    check_state("fault_hold", 32'h0040_2000, 1'b0, 1'b1, 32'h0040_2000, 16'd8);

    fault_ack = 1'b1;
    tick();
    check_state("fault_ack", 32'h0040_0800, 1'b1, 1'b0, 32'h0040_2000, 16'd8);
    fault_ack = 1'b0;
    tick();
    check_state("after_ack", 32'h0040_0804, 1'b1, 1'b0, 32'h0040_2000, 16'd9);

    redirect = 1'b1; redirect_pc = 32'h0040_3000;
    tick();
    redirect = 1'b0;
    tick();
    check_state("fault2", 32'h0040_3000, 1'b0, 1'b1, 32'h0040_3000, 16'd10);

    rst = 1'b1;
    tick();
    check_state("rst_in_fault", 32'h0040_0000, 1'b0, 1'b0, 32'h0, 16'd0);
    rst = 1'b0;
    tick();
    check_state("rerun", 32'h0040_0000, 1'b1, 1'b0, 32'h0, 16'd0);

    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) check("count4_at_15", {28'd0, fetch_count4}, 32'h0000_000F);
    end
    check("count4_saturated", {28'd0, fetch_count4}, 32'h0000_000F);
    check("count4_vpc", vpc4, 32'h0040_0050);
    check_state("run20", 32'h0040_0050, 1'b1, 1'b0, 32'h0, 16'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
